// File: rtl/pipes_pkg.sv
// Shared geometry, clamp bounds and FSM state type for the scrolling pipe field.
package pipes_pkg;

    localparam int CAP_H   = 33;
    localparam int CAP_W   = 90;
    localparam int BORDER  = 3;
    localparam int BODY_L  = 9;
    localparam int BODY_R  = 81;
    localparam int GAP_MIN = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FROZEN
    } field_state_t;

endpackage

// File: rtl/pipe_sprite_hit.sv
// Per-pipe pixel classifier: registers whether the raster pixel hits green or black
// parts of the top/bottom pipe pair located at pipe_x with opening top at pipe_gap.
module pipe_sprite_hit
    import pipes_pkg::*;
#(
    parameter int GAP      = 150,
    parameter int GROUND_Y = 428
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] pipe_x,
    input  logic [15:0] pipe_gap,
    input  logic [15:0] CounterX,
    input  logic [15:0] CounterY,
    output logic        green_p0,
    output logic        black_p0
);

    function automatic logic in_span(input logic [16:0] v, input logic [16:0] lo,
                                     input logic [16:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic [16:0] px, py, x0, top_y, bot_y;
    logic        col_cap, col_cap_blk, col_body, col_body_blk;
    logic        top_body, top_cap, top_cap_blk;
    logic        bot_body, bot_cap, bot_cap_blk;
    logic        cap_in, cap_blk, body_in, body_blk;
    logic        green_any, black_any;

    // 17-bit arithmetic so pipe_x + offset never wraps near the right edge
    assign px    = {1'b0, CounterX};
    assign py    = {1'b0, CounterY};
    assign x0    = {1'b0, pipe_x};
    assign top_y = {1'b0, pipe_gap};
    assign bot_y = top_y + 17'(GAP);

    assign col_cap      = in_span(px, x0, x0 + 17'(CAP_W));
    assign col_cap_blk  = in_span(px, x0, x0 + 17'(BORDER)) |
                          in_span(px, x0 + 17'(CAP_W - BORDER), x0 + 17'(CAP_W));
    assign col_body     = in_span(px, x0 + 17'(BODY_L), x0 + 17'(BODY_R));
    assign col_body_blk = in_span(px, x0 + 17'(BODY_L), x0 + 17'(BODY_L + BORDER)) |
                          in_span(px, x0 + 17'(BODY_R - BORDER), x0 + 17'(BODY_R));

    assign top_body    = (py <= top_y);
    assign top_cap     = in_span(py, top_y, top_y + 17'(CAP_H));
    assign top_cap_blk = in_span(py, top_y, top_y + 17'(BORDER)) |
                         in_span(py, top_y + 17'(CAP_H - BORDER), top_y + 17'(CAP_H));

    // Bottom pipe mirrors the top one: cap on its upper edge, body down to the ground
    assign bot_body    = in_span(py, bot_y, 17'(GROUND_Y));
    assign bot_cap     = in_span(py, bot_y, bot_y + 17'(CAP_H));
    assign bot_cap_blk = in_span(py, bot_y, bot_y + 17'(BORDER)) |
                         in_span(py, bot_y + 17'(CAP_H - BORDER), bot_y + 17'(CAP_H));

    assign cap_in   = col_cap & (top_cap | bot_cap);
    assign cap_blk  = col_cap & ((top_cap & (top_cap_blk | col_cap_blk)) |
                                 (bot_cap & (bot_cap_blk | col_cap_blk)));
    assign body_in  = col_body & (top_body | bot_body);
    assign body_blk = body_in & col_body_blk;

    assign black_any = cap_blk | body_blk;
    assign green_any = (cap_in | body_in) & ~black_any;

    // Stage p0: registered hit flags
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            green_p0 <= 1'b0;
            black_p0 <= 1'b0;
        end else begin
            green_p0 <= green_any;
            black_p0 <= black_any;
        end
    end

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe field: IDLE/RUN/FROZEN scroll control plus a 2-cycle colour mask path.
// Optional scoring (leading-pipe tracking and score_pulse) enabled by PIPE_FIELD_SCORE_EN.
module pipe_field
    import pipes_pkg::*;
#(
    parameter int NUM_PIPES = 2,
    parameter int SCREEN_W  = 640,
    parameter int SPACING   = 320,
    parameter int GAP       = 150,
    parameter int STEP      = 1,
    parameter int GROUND_Y  = 428,
    parameter int BIRD_X    = 160
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        tick,
    input  logic        Button,
    input  logic        Status,
    input  logic [15:0] CounterX,
    input  logic [15:0] CounterY,
    input  logic [15:0] PipesLong,
    output logic        R_Pipes_on,
    output logic        G_Pipes_on,
    output logic        B_Pipes_on,
    output logic        R_Pipes_off,
    output logic        G_Pipes_off,
    output logic        B_Pipes_off,
    output logic [15:0] PipesPosition,
    output logic [15:0] PipesGapY,
    output logic        score_pulse
);

`ifdef PIPE_FIELD_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    localparam int GAP_MAX  = GROUND_Y - GAP - CAP_H;
    localparam int WRAP_ADD = NUM_PIPES * SPACING - STEP;
    localparam int LEAD_W   = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    function automatic logic [15:0] clamp_gap(input logic [15:0] len);
        if (len < 16'(GAP_MIN))
            return 16'(GAP_MIN);
        else if (len > 16'(GAP_MAX))
            return 16'(GAP_MAX);
        else
            return len;
    endfunction

    function automatic logic [15:0] spawn_x(input int idx);
        return 16'(SCREEN_W + idx * SPACING);
    endfunction

    field_state_t          state_q, state_d;
    logic [15:0]           x_q   [NUM_PIPES];
    logic [15:0]           gap_q [NUM_PIPES];
    logic [LEAD_W-1:0]     lead_q;
    logic [15:0]           lead_x, lead_gap;
    logic [16:0]           lead_right;
    logic                  enter_idle, run_tick;
    logic [NUM_PIPES-1:0]  green_p0, black_p0;
    logic                  green_any, black_any;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                ST_IDLE:   if (!Button)           state_d = ST_RUN;
                ST_RUN:    if (!Status)           state_d = ST_FROZEN;
                ST_FROZEN: if (!Button && Status) state_d = ST_IDLE;
                default:                          state_d = ST_IDLE;
            endcase
        end
    end

    assign enter_idle = tick && (state_q == ST_FROZEN) && (state_d == ST_IDLE);
    assign run_tick   = tick && (state_q == ST_RUN);

    // Wrapping pipe re-enters NUM_PIPES*SPACING further right, keeping spacing exact
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i]   <= spawn_x(i);
                gap_q[i] <= 16'(GAP_MIN);
            end
        end else if (enter_idle) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i]   <= spawn_x(i);
                gap_q[i] <= clamp_gap(PipesLong);
            end
        end else if (run_tick) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (x_q[i] < 16'(STEP)) begin
                    x_q[i]   <= x_q[i] + 16'(WRAP_ADD);
                    gap_q[i] <= clamp_gap(PipesLong);
                end else begin
                    x_q[i] <= x_q[i] - 16'(STEP);
                end
            end
        end
    end

    always_comb begin
        lead_x   = x_q[0];
        lead_gap = gap_q[0];
        for (int i = 1; i < NUM_PIPES; i++) begin
            if (lead_q == LEAD_W'(i)) begin
                lead_x   = x_q[i];
                lead_gap = gap_q[i];
            end
        end
    end

    assign lead_right = {1'b0, lead_x} + 17'(CAP_W);

    // Pass test uses the pre-scroll X of the tick that moves the pipe
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            lead_q      <= '0;
            score_pulse <= 1'b0;
        end else begin
            score_pulse <= 1'b0;
            if (enter_idle) begin
                lead_q <= '0;
            end else if (SCORE_EN && run_tick && (lead_right < 17'(BIRD_X))) begin
                score_pulse <= 1'b1;
                lead_q      <= (lead_q == LEAD_W'(NUM_PIPES - 1)) ? '0 : lead_q + LEAD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            PipesPosition <= 16'(SCREEN_W);
            PipesGapY     <= 16'(GAP_MIN);
        end else begin
            PipesPosition <= lead_x;
            PipesGapY     <= lead_gap;
        end
    end

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_sprite
        pipe_sprite_hit #(
            .GAP      (GAP),
            .GROUND_Y (GROUND_Y)
        ) u_hit (
            .clk      (clk),
            .Reset    (Reset),
            .pipe_x   (x_q[g]),
            .pipe_gap (gap_q[g]),
            .CounterX (CounterX),
            .CounterY (CounterY),
            .green_p0 (green_p0[g]),
            .black_p0 (black_p0[g])
        );
    end

    assign black_any = |black_p0;
    assign green_any = (|green_p0) & ~black_any;

    // Stage p1: merged colour masks, two cycles after the raster position
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            G_Pipes_on  <= 1'b0;
            G_Pipes_off <= 1'b0;
            R_Pipes_off <= 1'b0;
        end else begin
            G_Pipes_on  <= green_any;
            G_Pipes_off <= black_any;
            R_Pipes_off <= green_any | black_any;
        end
    end

    assign R_Pipes_on  = 1'b0;
    assign B_Pipes_on  = 1'b0;
    assign B_Pipes_off = R_Pipes_off;

endmodule

// File: tb/tb_pipe_field.sv
// Directed self-checking bench for pipe_field (default geometry parameters).
module tb_pipe_field;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        tick = 1'b0;
    logic        Button = 1'b1;
    logic        Status = 1'b1;
    logic [15:0] CounterX = '0;
    logic [15:0] CounterY = '0;
    logic [15:0] PipesLong = 16'd400;
    logic        R_Pipes_on, G_Pipes_on, B_Pipes_on;
    logic        R_Pipes_off, G_Pipes_off, B_Pipes_off;
    logic [15:0] PipesPosition, PipesGapY;
    logic        score_pulse;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    pipe_field dut (
        .clk           (clk),
        .Reset         (Reset),
        .tick          (tick),
        .Button        (Button),
        .Status        (Status),
        .CounterX      (CounterX),
        .CounterY      (CounterY),
        .PipesLong     (PipesLong),
        .R_Pipes_on    (R_Pipes_on),
        .G_Pipes_on    (G_Pipes_on),
        .B_Pipes_on    (B_Pipes_on),
        .R_Pipes_off   (R_Pipes_off),
        .G_Pipes_off   (G_Pipes_off),
        .B_Pipes_off   (B_Pipes_off),
        .PipesPosition (PipesPosition),
        .PipesGapY     (PipesGapY),
        .score_pulse   (score_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick(input logic btn, input logic st);
        Button = btn;
        Status = st;
        tick   = 1'b1;
        step(1);
        if (score_pulse) pulses++;
        tick   = 1'b0;
        Button = 1'b1;
        Status = 1'b1;
    endtask

    task automatic pix(input int x, input int y);
        CounterX = 16'(x);
        CounterY = 16'(y);
        step(2);
    endtask

    task automatic chk_colour(input string tag, input logic gon, input logic goff, input logic roff);
        chk_eq({tag, "_Gon"},  G_Pipes_on,  gon);
        chk_eq({tag, "_Goff"}, G_Pipes_off, goff);
        chk_eq({tag, "_Roff"}, R_Pipes_off, roff);
        chk_eq({tag, "_Boff"}, B_Pipes_off, roff);
        chk_eq({tag, "_RBon"}, {R_Pipes_on, B_Pipes_on}, 0);
    endtask

    initial begin
        // Reset state
        step(2);
        chk_colour("rst", 1'b0, 1'b0, 1'b0);
        chk_eq("rst_score", score_pulse, 0);
        chk_eq("rst_pos", PipesPosition, 640);
        chk_eq("rst_gap", PipesGapY, 40);
        chk_eq("rst_x1", dut.x_q[1], 960);
        Reset = 1'b0;
        step(1);

        // Pixel path live in IDLE: pipe0 at 640, gap 40, body interior at (690,10)
        pix(690, 10);
        chk_colour("idle_body", 1'b1, 1'b0, 1'b1);

        // Start and scroll 10 ticks
        do_tick(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) do_tick(1'b1, 1'b1);
        step(1);
        chk_eq("run10_pos", PipesPosition, 630);
        chk_eq("run10_x1", dut.x_q[1], 950);
        chk_eq("run10_gap", PipesGapY, 40);

        // Collision tick still scrolls once, then the field freezes
        do_tick(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) do_tick(1'b1, 1'b1);
        do_tick(1'b0, 1'b0);
        step(1);
        chk_eq("frozen_pos", PipesPosition, 629);

        // Restart into IDLE reloads positions and gaps
        PipesLong = 16'd200;
        do_tick(1'b0, 1'b1);
        step(1);
        chk_eq("idle_pos", PipesPosition, 640);
        chk_eq("idle_gap", PipesGapY, 200);
        chk_eq("idle_x1", dut.x_q[1], 960);

        // Scroll pipe0 to X=100 (pipe1 at 420)
        do_tick(1'b0, 1'b1);
        for (int i = 0; i < 540; i++) do_tick(1'b1, 1'b1);
        step(1);
        chk_eq("x100_pos", PipesPosition, 100);

        pix(110, 100);
        chk_colour("body_edge", 1'b0, 1'b1, 1'b1);
        pix(150, 100);
        chk_colour("body_mid", 1'b1, 1'b0, 1'b1);
        pix(150, 360);
        chk_colour("bot_cap", 1'b1, 1'b0, 1'b1);
        pix(100, 200);
        chk_colour("cap_corner", 1'b0, 1'b1, 1'b1);
        pix(190, 233);
        chk_colour("cap_far", 1'b0, 1'b1, 1'b1);
        pix(300, 300);
        chk_colour("empty", 1'b0, 1'b0, 1'b0);

        // Exact two-cycle latency
        CounterX = 16'd150;
        CounterY = 16'd100;
        step(1);
        CounterX = 16'd300;
        CounterY = 16'd300;
        step(1);
        chk_eq("lat2_on", G_Pipes_on, 1);
        step(1);
        chk_eq("lat3_off", G_Pipes_on, 0);

        // Scroll to X=0 through the bird crossing (69->68)
        pulses    = 0;
        PipesLong = 16'd400;
        for (int i = 0; i < 100; i++) do_tick(1'b1, 1'b1);
        step(1);
        chk_eq("x0", dut.x_q[0], 0);
`ifdef PIPE_FIELD_SCORE_EN
        chk_eq("score_cnt", pulses, 1);
        chk_eq("lead_pos", PipesPosition, 320);
`else
        chk_eq("score_cnt", pulses, 0);
        chk_eq("lead_pos", PipesPosition, 0);
`endif

        // Wrap: 0 -> 639 with clamped gap 245
        do_tick(1'b1, 1'b1);
        step(1);
        chk_eq("wrap_x", dut.x_q[0], 639);
        chk_eq("wrap_gap", dut.gap_q[0], 245);
        chk_eq("wrap_x1", dut.x_q[1], 319);
`ifdef PIPE_FIELD_SCORE_EN
        chk_eq("wrap_gapy", PipesGapY, 200);
`else
        chk_eq("wrap_gapy", PipesGapY, 245);
`endif

        // Mid-run reset: pipe1 body interior at (369,100)
        pix(369, 100);
        chk_eq("pre_rst_on", G_Pipes_on, 1);
        #1;
        Reset = 1'b1;
        #1;
        chk_colour("async_rst", 1'b0, 1'b0, 1'b0);
        chk_eq("async_rst_score", score_pulse, 0);
        step(1);
        chk_eq("rst_run_pos", PipesPosition, 640);
        chk_eq("rst_run_x0", dut.x_q[0], 640);
        Reset = 1'b0;
        step(1);

        // Status=0 with Button=0 in RUN freezes (no restart)
        do_tick(1'b0, 1'b1);
        do_tick(1'b1, 1'b1);
        do_tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b1);
        step(1);
        chk_eq("both_low_x", dut.x_q[0], 638);

        // Low clamp on restart
        PipesLong = 16'd5;
        do_tick(1'b0, 1'b1);
        step(1);
        chk_eq("clamp_lo_pos", PipesPosition, 640);
        chk_eq("clamp_lo_gap", PipesGapY, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_field.md
PIPE_FIELD -- requirements
Module: pipe_field

Interface
REQ-001 Parameter NUM_PIPES, default 2, number of independently scrolling pipe pairs (1..4).
REQ-002 Parameter SCREEN_W, default 640, pipe spawn X and visible width.
REQ-003 Parameter SPACING, default 320, horizontal distance between successive pipes; NUM_PIPES*SPACING >= SCREEN_W.
REQ-004 Parameter GAP, default 150, vertical opening between top and bottom pipe.
REQ-005 Parameter STEP, default 1, pixels moved per tick (1..8).
REQ-006 Parameters GROUND_Y, default 428, and BIRD_X, default 160.
REQ-007 clk  in  1  pixel clock.
REQ-008 Reset  in  1  asynchronous, active-high reset.
REQ-009 tick  in  1  one-cycle scroll strobe.
REQ-010 Button  in  1  active-low player button.
REQ-011 Status  in  1  1 = game alive, 0 = collision.
REQ-012 CounterX, CounterY  in  16 each  current raster pixel.
REQ-013 PipesLong  in  16  random top-pipe length for next spawn.
REQ-014 R_Pipes_on, G_Pipes_on, B_Pipes_on, R_Pipes_off, G_Pipes_off, B_Pipes_off  out  1 each  colour set/clear masks.
REQ-015 PipesPosition, PipesGapY  out  16 each  X and top length of leading pipe.
REQ-016 score_pulse  out  1  one-cycle pulse per pipe passed (REQ-031).

Function
REQ-017 FSM states IDLE, RUN, FROZEN; all transitions evaluated only in cycles where tick=1.
REQ-018 IDLE->RUN when Button=0; RUN->FROZEN when Status=0; FROZEN->IDLE when Button=0 and Status=1; Status=0 and Button=0 together in RUN -> FROZEN.
REQ-019 Entering IDLE reloads pipe i X to SCREEN_W + i*SPACING and gap to clamped PipesLong; leading index to 0.
REQ-020 In RUN on tick, each X decrements by STEP; if X < STEP, X <= X + NUM_PIPES*SPACING - STEP and gap reloads from PipesLong (wrap, spacing preserved).
REQ-021 Gap Y = PipesLong clamped to [40, GROUND_Y-GAP-33]; PipesLong values outside clamp to nearest bound.
REQ-022 FROZEN and IDLE hold all X values unchanged.
REQ-023 Hit tests use 17-bit unsigned sums; X+offset never wraps.
REQ-024 Top pipe: body X+9..X+81, Y 0..gap; cap X+0..X+90, Y gap..gap+33; bottom pipe mirrors from gap+GAP down to GROUND_Y.
REQ-025 Cap: 3-px black border (rows 0..3 and 30..33, columns 0..3 and 87..90), green inside; body: 3-px black columns at 9..12 and 78..81, green 12..78; bounds inclusive.
REQ-026 Black has priority over green at overlapping pixels.
REQ-027 Colour outputs latency exactly 2 cycles from CounterX/CounterY.
REQ-028 G_on = green; R_on = B_on = 0; R_off = B_off = green|black; G_off = black.
REQ-029 Pixel path is live in all states (pipes drawn while IDLE/FROZEN).
REQ-030 PipesPosition/PipesGapY update one cycle after tick.
REQ-031 Leading pipe passed when X+90 < BIRD_X in RUN; leading index increments modulo NUM_PIPES; score_pulse high that cycle.

Reset
REQ-032 Reset: state IDLE, X_i = SCREEN_W + i*SPACING, gaps 40, leading 0, all colour outputs 0, score_pulse 0, PipesPosition = SCREEN_W.
REQ-033 Reset mid-frame takes effect immediately; pipeline stages cleared.

Configuration
REQ-034 Macro PIPE_FIELD_SCORE_EN: defined -> REQ-031 logic and score_pulse active; undefined -> score_pulse tied 0, leading index fixed 0, PipesPosition follows pipe 0.

Structure
REQ-035 Package pipes_pkg: geometry constants (cap 33/90, border 3, body 9/81), FSM state typedef, gap clamp bounds.
REQ-036 Sub-module pipe_sprite_hit: one per pipe, registered green/black hit from X, gap, CounterX/Y.

Verification
REQ-037 Reset, tick with Button=0 -> RUN; 10 ticks -> pipe0 X=630, pipe1 X=950.
REQ-038 pipe0 X=0, tick (STEP=1) -> X=639, gap = clamped PipesLong; PipesLong=400 -> gap 245.
REQ-039 X=100, gap=200, pixel (110,100) -> G_off=1 two cycles later; (150,100) -> G_on=1; (150,360) -> G_on=1 (bottom body).
REQ-040 Status=0 on tick -> FROZEN, X stable over 20 ticks; Button=0,Status=1 -> IDLE, X reloaded 640.
REQ-041 SCORE_EN: pipe0 X crosses 69->68 with BIRD_X=160 -> one score_pulse, PipesPosition switches to pipe1.
REQ-042 Reset asserted mid-RUN -> all outputs 0 next cycle, X=640.
